// File: rtl/spu_issue_pkg.sv
// Shared types and default widths for the dual-issue hazard controller.
//   issue_state_t : RUN (whole pair can be considered) / SPLIT (slot1 already gone)
//   slot_t        : one decoded ID slot as seen by the issue logic
package spu_issue_pkg;

  localparam int SPU_NUM_REGS = 128;
  localparam int SPU_REG_W    = 7;
  localparam int SPU_LAT_W    = 3;
  localparam int SPU_STALL_CW = 16;

  typedef enum logic {
    RUN   = 1'b0,
    SPLIT = 1'b1
  } issue_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 wen;
    logic [SPU_REG_W-1:0] rt;
    logic [SPU_REG_W-1:0] ra;
    logic [SPU_REG_W-1:0] rb;
    logic [SPU_REG_W-1:0] rc;
    logic                 use_ra;
    logic                 use_rb;
    logic                 use_rc;
    logic [SPU_LAT_W-1:0] latency;
  } slot_t;

endpackage

// File: rtl/issue_hazard_check.sv
// Combinational hazard test for one ID slot.
//   busy            : per-register "result not yet readable" vector
//   valid/wen/rt/.. : the slot under test
//   intra_en        : enable compare against the older slot of the same pair
//   older_wen/rt    : older slot's write (only meaningful with intra_en)
//   haz             : slot must not issue this cycle
module issue_hazard_check
  import spu_issue_pkg::*;
#(
  parameter int NUM_REGS = SPU_NUM_REGS,
  parameter int REG_W    = SPU_REG_W
) (
  input  logic [NUM_REGS-1:0] busy,
  input  logic                valid,
  input  logic                wen,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    ra,
  input  logic [REG_W-1:0]    rb,
  input  logic [REG_W-1:0]    rc,
  input  logic                use_ra,
  input  logic                use_rb,
  input  logic                use_rc,
  input  logic                intra_en,
  input  logic                older_wen,
  input  logic [REG_W-1:0]    older_rt,
  output logic                haz
);

  logic src_busy;
  logic waw_busy;
  logic intra_haz;

  always_comb begin
    src_busy  = (use_ra & busy[ra]) | (use_rb & busy[rb]) | (use_rc & busy[rc]);
    waw_busy  = wen & busy[rt];
    // Older slot's result cannot be forwarded within the same issue cycle.
    intra_haz = intra_en & older_wen &
                ((use_ra & (ra == older_rt)) |
                 (use_rb & (rb == older_rt)) |
                 (use_rc & (rc == older_rt)) |
                 (wen    & (rt == older_rt)));
    haz       = valid & (src_busy | waw_busy | intra_haz);
  end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Dual-issue hazard/stall controller for the ID->REG register pair.
// Slot1 is the older instruction, slot2 the younger.
//   clk, reset (sync, active-low)
//   *_ID1/*_ID2          : decoded pair presented by ID
//   flush                : kill both ID slots this cycle
//   id_hold              : decoder keeps the same pair next cycle
//   bubble_REG1/2        : ID/REG slot loads zeros
//   issue_REG1/2         : slot accepted into ID/REG this cycle
//   stall_count          : saturating count of stall + split cycles
//
// state | meaning
// RUN   | pair evaluated as a whole: issue both, split, or stall
// SPLIT | slot1 already issued; only slot2 of the held pair is pending
module issue_hazard_ctrl
  import spu_issue_pkg::*;
#(
  parameter int NUM_REGS = SPU_NUM_REGS,
  parameter int REG_W    = SPU_REG_W,
  parameter int LAT_W    = SPU_LAT_W,
  parameter int STALL_CW = SPU_STALL_CW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_ID1,
  input  logic                valid_ID2,
  input  logic                regWriteEnable_ID1,
  input  logic                regWriteEnable_ID2,
  input  logic [REG_W-1:0]    readRegisterRT_ID1,
  input  logic [REG_W-1:0]    readRegisterRT_ID2,
  input  logic [REG_W-1:0]    readRegisterRA_ID1,
  input  logic [REG_W-1:0]    readRegisterRA_ID2,
  input  logic [REG_W-1:0]    readRegisterRB_ID1,
  input  logic [REG_W-1:0]    readRegisterRB_ID2,
  input  logic [REG_W-1:0]    readRegisterRC_ID1,
  input  logic [REG_W-1:0]    readRegisterRC_ID2,
  input  logic                useRA_ID1,
  input  logic                useRA_ID2,
  input  logic                useRB_ID1,
  input  logic                useRB_ID2,
  input  logic                useRC_ID1,
  input  logic                useRC_ID2,
  input  logic [LAT_W-1:0]    latency_ID1,
  input  logic [LAT_W-1:0]    latency_ID2,
  input  logic                flush,
  output logic                id_hold,
  output logic                bubble_REG1,
  output logic                bubble_REG2,
  output logic                issue_REG1,
  output logic                issue_REG2,
  output logic [STALL_CW-1:0] stall_count
);

  slot_t               s1, s2;
  logic [NUM_REGS-1:0] busy;
  logic                haz1, haz2;
  logic                stall_inc;
  issue_state_t        state_q, state_d;
  logic [LAT_W-1:0]    lat_q [NUM_REGS];
  logic [LAT_W-1:0]    lat_d [NUM_REGS];
  logic [STALL_CW-1:0] stall_count_q, stall_count_d;

  always_comb begin
    s1.valid   = valid_ID1;          s2.valid   = valid_ID2;
    s1.wen     = regWriteEnable_ID1; s2.wen     = regWriteEnable_ID2;
    s1.rt      = readRegisterRT_ID1; s2.rt      = readRegisterRT_ID2;
    s1.ra      = readRegisterRA_ID1; s2.ra      = readRegisterRA_ID2;
    s1.rb      = readRegisterRB_ID1; s2.rb      = readRegisterRB_ID2;
    s1.rc      = readRegisterRC_ID1; s2.rc      = readRegisterRC_ID2;
    s1.use_ra  = useRA_ID1;          s2.use_ra  = useRA_ID2;
    s1.use_rb  = useRB_ID1;          s2.use_rb  = useRB_ID2;
    s1.use_rc  = useRC_ID1;          s2.use_rc  = useRC_ID2;
    s1.latency = latency_ID1;        s2.latency = latency_ID2;
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) busy[r] = (lat_q[r] != '0);
  end

  issue_hazard_check #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) u_chk1 (
    .busy(busy), .valid(s1.valid), .wen(s1.wen), .rt(s1.rt),
    .ra(s1.ra), .rb(s1.rb), .rc(s1.rc),
    .use_ra(s1.use_ra), .use_rb(s1.use_rb), .use_rc(s1.use_rc),
    .intra_en(1'b0), .older_wen(1'b0), .older_rt('0), .haz(haz1)
  );

  // Intra-pair terms only matter while slot1 has not yet issued.
  issue_hazard_check #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) u_chk2 (
    .busy(busy), .valid(s2.valid), .wen(s2.wen), .rt(s2.rt),
    .ra(s2.ra), .rb(s2.rb), .rc(s2.rc),
    .use_ra(s2.use_ra), .use_rb(s2.use_rb), .use_rc(s2.use_rc),
    .intra_en(state_q == RUN), .older_wen(s1.valid & s1.wen),
    .older_rt(s1.rt), .haz(haz2)
  );

  always_comb begin
    state_d     = state_q;
    id_hold     = 1'b0;
    bubble_REG1 = 1'b1;
    bubble_REG2 = 1'b1;
    issue_REG1  = 1'b0;
    issue_REG2  = 1'b0;
    stall_inc   = 1'b0;
    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = RUN;
        end else if (haz1) begin
          id_hold   = 1'b1;
          stall_inc = 1'b1;
        end else if (s2.valid && haz2) begin
          issue_REG1  = s1.valid;
          bubble_REG1 = ~s1.valid;
          id_hold     = 1'b1;
          stall_inc   = 1'b1;
          state_d     = SPLIT;
        end else begin
          issue_REG1  = s1.valid;
          bubble_REG1 = ~s1.valid;
          issue_REG2  = s2.valid;
          bubble_REG2 = ~s2.valid;
        end
      end
      SPLIT: begin
        if (flush) begin
          state_d = RUN;
        end else if (haz2) begin
          id_hold   = 1'b1;
          stall_inc = 1'b1;
        end else begin
          issue_REG2  = s2.valid;
          bubble_REG2 = ~s2.valid;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (!reset) begin
      id_hold     = 1'b0;
      bubble_REG1 = 1'b1;
      bubble_REG2 = 1'b1;
      issue_REG1  = 1'b0;
      issue_REG2  = 1'b0;
      stall_inc   = 1'b0;
    end
  end

  // A new write latency overrides the per-cycle decrement of that entry.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      lat_d[r] = (lat_q[r] != '0) ? lat_q[r] - LAT_W'(1) : '0;
    if (issue_REG1 && s1.wen) lat_d[s1.rt] = s1.latency;
    if (issue_REG2 && s2.wen) lat_d[s2.rt] = s2.latency;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_inc && (stall_count_q != '1))
      stall_count_d = stall_count_q + STALL_CW'(1);
  end

  assign stall_count = stall_count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RUN;
      stall_count_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) lat_q[r] <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      for (int r = 0; r < NUM_REGS; r++) lat_q[r] <= lat_d[r];
    end
  end

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Scoreboard bench: each directed cycle pushes its expected outputs; a
// negedge monitor pops and compares against what the controller presents.
module tb_issue_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        valid_ID1, valid_ID2, regWriteEnable_ID1, regWriteEnable_ID2;
  logic [6:0]  readRegisterRT_ID1, readRegisterRT_ID2;
  logic [6:0]  readRegisterRA_ID1, readRegisterRA_ID2;
  logic [6:0]  readRegisterRB_ID1, readRegisterRB_ID2;
  logic [6:0]  readRegisterRC_ID1, readRegisterRC_ID2;
  logic        useRA_ID1, useRA_ID2, useRB_ID1, useRB_ID2, useRC_ID1, useRC_ID2;
  logic [2:0]  latency_ID1, latency_ID2;
  logic        id_hold, bubble_REG1, bubble_REG2, issue_REG1, issue_REG2;
  logic [15:0] stall_count;

  typedef struct packed {
    logic        hold;
    logic        b1;
    logic        b2;
    logic        i1;
    logic        i2;
    logic [15:0] sc;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_sc;
  exp_t        mon_e, mon_a;
  string       mon_n;

  issue_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .valid_ID1(valid_ID1), .valid_ID2(valid_ID2),
    .regWriteEnable_ID1(regWriteEnable_ID1), .regWriteEnable_ID2(regWriteEnable_ID2),
    .readRegisterRT_ID1(readRegisterRT_ID1), .readRegisterRT_ID2(readRegisterRT_ID2),
    .readRegisterRA_ID1(readRegisterRA_ID1), .readRegisterRA_ID2(readRegisterRA_ID2),
    .readRegisterRB_ID1(readRegisterRB_ID1), .readRegisterRB_ID2(readRegisterRB_ID2),
    .readRegisterRC_ID1(readRegisterRC_ID1), .readRegisterRC_ID2(readRegisterRC_ID2),
    .useRA_ID1(useRA_ID1), .useRA_ID2(useRA_ID2),
    .useRB_ID1(useRB_ID1), .useRB_ID2(useRB_ID2),
    .useRC_ID1(useRC_ID1), .useRC_ID2(useRC_ID2),
    .latency_ID1(latency_ID1), .latency_ID2(latency_ID2),
    .flush(flush),
    .id_hold(id_hold), .bubble_REG1(bubble_REG1), .bubble_REG2(bubble_REG2),
    .issue_REG1(issue_REG1), .issue_REG2(issue_REG2),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_a = {id_hold, bubble_REG1, bubble_REG2, issue_REG1, issue_REG2, stall_count};
      total++;
      if (mon_a !== mon_e) begin
        bad++;
        $display("FAIL %s: got hold=%b bub=%b%b iss=%b%b cnt=%0d, want hold=%b bub=%b%b iss=%b%b cnt=%0d",
                 mon_n, mon_a.hold, mon_a.b1, mon_a.b2, mon_a.i1, mon_a.i2, mon_a.sc,
                 mon_e.hold, mon_e.b1, mon_e.b2, mon_e.i1, mon_e.i2, mon_e.sc);
      end
    end
  end

  task automatic chk(input string n, input logic ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL %s", n);
    end
  endtask

  task automatic clr();
    flush = 0;
    valid_ID1 = 0; regWriteEnable_ID1 = 0; latency_ID1 = 0;
    readRegisterRT_ID1 = 0; readRegisterRA_ID1 = 0; readRegisterRB_ID1 = 0; readRegisterRC_ID1 = 0;
    useRA_ID1 = 0; useRB_ID1 = 0; useRC_ID1 = 0;
    valid_ID2 = 0; regWriteEnable_ID2 = 0; latency_ID2 = 0;
    readRegisterRT_ID2 = 0; readRegisterRA_ID2 = 0; readRegisterRB_ID2 = 0; readRegisterRC_ID2 = 0;
    useRA_ID2 = 0; useRB_ID2 = 0; useRC_ID2 = 0;
  endtask

  task automatic set_s1(input logic w, input logic [6:0] rt, input logic [6:0] ra, input logic ua,
                        input logic [6:0] rb, input logic ub, input logic [6:0] rc, input logic uc,
                        input logic [2:0] lat);
    valid_ID1 = 1; regWriteEnable_ID1 = w; readRegisterRT_ID1 = rt;
    readRegisterRA_ID1 = ra; useRA_ID1 = ua; readRegisterRB_ID1 = rb; useRB_ID1 = ub;
    readRegisterRC_ID1 = rc; useRC_ID1 = uc; latency_ID1 = lat;
  endtask

  task automatic set_s2(input logic w, input logic [6:0] rt, input logic [6:0] ra, input logic ua,
                        input logic [6:0] rb, input logic ub, input logic [6:0] rc, input logic uc,
                        input logic [2:0] lat);
    valid_ID2 = 1; regWriteEnable_ID2 = w; readRegisterRT_ID2 = rt;
    readRegisterRA_ID2 = ra; useRA_ID2 = ua; readRegisterRB_ID2 = rb; useRB_ID2 = ub;
    readRegisterRC_ID2 = rc; useRC_ID2 = uc; latency_ID2 = lat;
  endtask

  // Push the expected outputs of the current cycle, advance the count model, step one clock.
  task automatic step(input string n, input logic h, input logic b1, input logic b2,
                      input logic i1, input logic i2);
    exp_t e;
    e = {h, b1, b2, i1, i2, exp_sc};
    exp_q.push_back(e);
    name_q.push_back(n);
    if (!reset) exp_sc = '0;
    else if (h && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 0; clr(); exp_sc = '0;
    repeat (2) @(posedge clk);
    #1;
    // Outputs forced while reset is low, even with a valid pair presented.
    set_s1(1, 5, 0, 0, 0, 0, 0, 0, 2); set_s2(1, 6, 0, 0, 0, 0, 0, 0, 1);
    step("rst_outputs", 0, 1, 1, 0, 0);
    chk("rst_state", (dut.state_q == spu_issue_pkg::RUN) && (dut.lat_q[5] == 3'd0) &&
                     (dut.lat_q[6] == 3'd0) && (stall_count == 16'd0));
    reset = 1;

    // 1. independent pair, then prove lat[5]==2 by stall length
    clr(); set_s1(1, 5, 0, 0, 0, 0, 0, 0, 2); set_s2(0, 0, 6, 1, 0, 0, 0, 0, 0);
    step("t1_pair", 0, 0, 0, 1, 1);
    chk("t1_lat5", dut.lat_q[5] == 3'd2);
    clr(); set_s1(0, 0, 5, 1, 0, 0, 0, 0, 0);
    step("t1_raw_a", 1, 1, 1, 0, 0);
    step("t1_raw_b", 1, 1, 1, 0, 0);
    step("t1_go",    0, 0, 1, 1, 0);

    // 2. cross-cycle RAW, counted from a fresh reset
    clr(); reset = 0; step("t2_rst", 0, 1, 1, 0, 0); reset = 1;
    set_s1(1, 10, 0, 0, 0, 0, 0, 0, 3);
    step("t2_wr", 0, 0, 1, 1, 0);
    clr(); set_s1(0, 0, 10, 1, 0, 0, 0, 0, 0);
    step("t2_stall1", 1, 1, 1, 0, 0);
    step("t2_stall2", 1, 1, 1, 0, 0);
    step("t2_stall3", 1, 1, 1, 0, 0);
    chk("t2_lat10_expired", dut.lat_q[10] == 3'd0);
    step("t2_go",     0, 0, 1, 1, 0);
    chk("t2_count3", stall_count == 16'd3);
    clr(); step("t2_cnt3", 0, 1, 1, 0, 0);

    // 3. intra-pair RAW through RB, zero latency
    set_s1(1, 20, 0, 0, 0, 0, 0, 0, 0); set_s2(0, 0, 0, 0, 20, 1, 0, 0, 0);
    step("t3_split",  1, 0, 1, 1, 0);
    step("t3_issue2", 0, 1, 0, 0, 1);
    clr(); step("t3_run", 0, 1, 1, 0, 0);

    // 4. intra-pair WAW: slot2 waits for lat[7] to drain, then its own latency applies
    set_s1(1, 7, 0, 0, 0, 0, 0, 0, 3); set_s2(1, 7, 0, 0, 0, 0, 0, 0, 1);
    step("t4_split",  1, 0, 1, 1, 0);
    step("t4_wait1",  1, 1, 1, 0, 0);
    step("t4_wait2",  1, 1, 1, 0, 0);
    step("t4_wait3",  1, 1, 1, 0, 0);
    step("t4_issue2", 0, 1, 0, 0, 1);
    clr(); set_s1(0, 0, 0, 0, 0, 0, 7, 1, 0);
    step("t4_rc_raw", 1, 1, 1, 0, 0);
    step("t4_go",     0, 0, 1, 1, 0);

    // 5a. flush during a stall keeps the scoreboard
    clr(); set_s1(1, 30, 0, 0, 0, 0, 0, 0, 4);
    step("t5_wr", 0, 0, 1, 1, 0);
    clr(); set_s1(0, 0, 30, 1, 0, 0, 0, 0, 0);
    step("t5_stall", 1, 1, 1, 0, 0);
    flush = 1; step("t5_flush_stall", 0, 1, 1, 0, 0); flush = 0;
    step("t5_kept_a", 1, 1, 1, 0, 0);
    step("t5_kept_b", 1, 1, 1, 0, 0);
    step("t5_go",     0, 0, 1, 1, 0);

    // 5b. flush during SPLIT returns to RUN
    clr(); set_s1(1, 40, 0, 0, 0, 0, 0, 0, 2); set_s2(0, 0, 40, 1, 0, 0, 0, 0, 0);
    step("t5_split", 1, 0, 1, 1, 0);
    flush = 1; step("t5_flush_split", 0, 1, 1, 0, 0); flush = 0;
    clr(); set_s1(0, 0, 40, 1, 0, 0, 0, 0, 0);
    step("t5_run_stall", 1, 1, 1, 0, 0);
    step("t5_go2",       0, 0, 1, 1, 0);

    // 6. reset mid-SPLIT clears lat[3] and state
    clr(); set_s1(1, 3, 0, 0, 0, 0, 0, 0, 5); set_s2(0, 0, 3, 1, 0, 0, 0, 0, 0);
    step("t6_split", 1, 0, 1, 1, 0);
    step("t6_wait",  1, 1, 1, 0, 0);
    reset = 0; step("t6_rst", 0, 1, 1, 0, 0); reset = 1;
    chk("t6_rst_state", (dut.state_q == spu_issue_pkg::RUN) && (dut.lat_q[3] == 3'd0));
    clr(); set_s1(0, 0, 3, 1, 0, 0, 0, 0, 0);
    step("t6_cleared", 0, 0, 1, 1, 0);

    // 6b. counter preset to all-ones must not wrap under stalls
    clr(); set_s1(1, 9, 0, 0, 0, 0, 0, 0, 2);
    force dut.stall_count_q = 16'hFFFF;
    exp_sc = 16'hFFFF;
    step("t6_sat_set", 0, 0, 1, 1, 0);
    release dut.stall_count_q;
    clr(); set_s1(0, 0, 9, 1, 0, 0, 0, 0, 0);
    step("t6_sat_a",  1, 1, 1, 0, 0);
    step("t6_sat_b",  1, 1, 1, 0, 0);
    step("t6_sat_go", 0, 0, 1, 1, 0);

    clr();
    @(posedge clk); #1;
    chk("all_expectations_consumed", exp_q.size() == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
